// File: rtl/data_mem_ctrl.sv
// Byte-addressed little-endian data memory for the load/store path.
// A valid/ready request port feeds an in-order response pipeline of RD_LAT
// stages. Sized, sign/zero-extended loads are supported, misaligned accesses
// are faulted, and an optional zero-clear sweep runs after reset.
module data_mem_ctrl #(
   parameter int DATA_W         = 32,
   parameter int ADDR_W         = 10,
   parameter int RD_LAT         = 1,
   parameter bit CLEAR_ON_RESET = 1'b1
) (
   input  logic                             clk,
   input  logic                             rst,
   input  logic                             req_valid,
   output logic                             req_ready,
   input  logic                             req_we,
   input  logic [ADDR_W+$clog2(DATA_W/8)-1:0] req_addr,
   input  logic [1:0]                       req_size,
   input  logic                             req_signed,
   input  logic [DATA_W-1:0]                req_wdata,
   output logic                             rsp_valid,
   output logic [DATA_W-1:0]                rsp_rdata,
   output logic                             rsp_err
);

   localparam int OFF_W = $clog2(DATA_W/8);
   localparam int NB    = DATA_W/8;
   localparam int DEPTH = 1 << ADDR_W;

   typedef enum logic {ST_CLEAR, ST_RUN} state_t;

   state_t              state;
   state_t              state_nxt;
   logic [ADDR_W-1:0]   clr_idx;
   logic                clr_we;
   logic                clr_last;

   logic [DATA_W-1:0]   mem [DEPTH];

   logic [ADDR_W-1:0]   word_idx;
   logic [OFF_W-1:0]    off;
   logic                accept;
   logic                acc_err;
   logic [NB-1:0]       lane_en;
   logic [DATA_W-1:0]   wdata_sh;
   logic [DATA_W-1:0]   rd_word;
   logic [DATA_W-1:0]   rsp_d;

   logic [RD_LAT-1:0]   vld_p;
   logic [RD_LAT-1:0]   err_p;
   logic [DATA_W-1:0]   data_p [RD_LAT];

   // A half must be 2-byte aligned, a word 4-byte aligned; a dword needs a
   // 64-bit array and a zero offset.
   function automatic logic misaligned(input logic [OFF_W-1:0] o, input logic [1:0] size);
      logic bad;
      case (size)
         2'b00:   bad = 1'b0;
         2'b01:   bad = o[0];
         2'b10:   bad = (o[1:0] != 2'b00);
         default: bad = (DATA_W == 32) || (o != '0);
      endcase
      return bad;
   endfunction

   // Lanes o .. o+2^size-1 are touched by an access.
   function automatic logic [NB-1:0] lane_mask(input logic [OFF_W-1:0] o, input logic [1:0] size);
      logic [NB-1:0] m;
      int            first;
      int            nbytes;
      first  = int'(o);
      nbytes = 1 << size;
      for (int b = 0; b < NB; b++) begin
         m[b] = (b >= first) && (b < first + nbytes);
      end
      return m;
   endfunction

   // Move the addressed lanes down to bit 0 and extend to the full width.
   function automatic logic [DATA_W-1:0] load_extend(input logic [DATA_W-1:0] word,
                                                      input logic [OFF_W-1:0]  o,
                                                      input logic [1:0]        size,
                                                      input logic              sgn);
      logic [DATA_W-1:0] sh;
      logic [DATA_W-1:0] res;
      logic              fill;
      int                nbits;
      sh    = word >> {o, 3'b000};
      nbits = 8 << size;
      if (nbits > DATA_W) begin
         nbits = DATA_W;
      end
      fill = 1'b0;
      for (int i = 0; i < DATA_W; i++) begin
         if (i == nbits - 1) begin
            fill = sgn & sh[i];
         end
      end
      for (int i = 0; i < DATA_W; i++) begin
         res[i] = (i < nbits) ? sh[i] : fill;
      end
      return res;
   endfunction

   assign word_idx = req_addr[ADDR_W+OFF_W-1:OFF_W];
   assign off      = req_addr[OFF_W-1:0];
   assign accept   = req_valid && req_ready;
   assign acc_err  = misaligned(off, req_size);
   assign lane_en  = lane_mask(off, req_size);
   assign wdata_sh = req_wdata << {off, 3'b000};
   assign rd_word  = mem[word_idx];
   assign rsp_d    = (req_we || acc_err) ? '0 : load_extend(rd_word, off, req_size, req_signed);
   assign clr_last = (clr_idx == {ADDR_W{1'b1}});

   // State register: reset parks the controller in CLEAR.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= ST_CLEAR;
      end else begin
         state <= state_nxt;
      end
   end

   // Next state: leave CLEAR once the last word is zeroed, or at once when no clear is wanted.
   always_comb begin
      state_nxt = state;
      case (state)
         ST_CLEAR: if (!CLEAR_ON_RESET || clr_last) state_nxt = ST_RUN;
         default:  state_nxt = ST_RUN;
      endcase
   end

   // Outputs: requests are taken only in RUN; the clear sweep writes only in CLEAR.
   always_comb begin
      req_ready = (state == ST_RUN);
      clr_we    = (state == ST_CLEAR) && CLEAR_ON_RESET;
   end

   // Clear sweep index restarts from word 0 on every reset.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         clr_idx <= '0;
      end else if (clr_we) begin
         clr_idx <= clr_idx + 1'b1;
      end
   end

   // Memory array write port: clear sweep or byte-lane store; contents survive reset.
   always_ff @(posedge clk) begin
      if (clr_we) begin
         mem[clr_idx] <= '0;
      end else if (accept && req_we && !acc_err) begin
         for (int b = 0; b < NB; b++) begin
            if (lane_en[b]) begin
               mem[word_idx][8*b +: 8] <= wdata_sh[8*b +: 8];
            end
         end
      end
   end

   // Response pipeline: stage 0 captures the formatted read at the accept edge,
   // later stages only delay it; non-response slots carry zeros.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         vld_p <= '0;
         err_p <= '0;
         for (int i = 0; i < RD_LAT; i++) begin
            data_p[i] <= '0;
         end
      end else begin
         vld_p[0]  <= accept;
         err_p[0]  <= accept && acc_err;
         data_p[0] <= accept ? rsp_d : '0;
         for (int i = 1; i < RD_LAT; i++) begin
            vld_p[i]  <= vld_p[i-1];
            err_p[i]  <= err_p[i-1];
            data_p[i] <= data_p[i-1];
         end
      end
   end

   assign rsp_valid = vld_p[RD_LAT-1];
   assign rsp_err   = err_p[RD_LAT-1];
   assign rsp_rdata = data_p[RD_LAT-1];

endmodule

// File: doc/data_mem_ctrl.md
Name: data_mem_ctrl

Overview:
- Next-generation single-clock data memory for the CPU load/store path.
- Byte-addressed and little-endian, with byte/half/word/dword sized accesses, signed or unsigned load extension and misalignment faults.
- Uses a valid/ready request port and an in-order response port with parametrised read latency.
- Optional zero-clear FSM runs after reset.
- Replaces the plain word-addressed, combinational-read data RAM between the execute/memory stage and the write-back stage.

Parameters:
- DATA_W, 32, word width in bits; legal values are 32 or 64. OFF_W = log2(DATA_W/8).
- ADDR_W, 10, word-index bits; depth = 2^ADDR_W words.
- RD_LAT, 1, response latency in cycles; legal range 1..4.
- CLEAR_ON_RESET, 1, 1 = zero every word after reset before accepting requests.

Ports:
- clk  in  1  system clock, rising edge
- rst  in  1  asynchronous active-high reset
- req_valid  in  1  request present
- req_ready  out  1  block can accept a request this cycle
- req_we  in  1  1 = store, 0 = load
- req_addr  in  ADDR_W+OFF_W  byte address
- req_size  in  2  00 byte, 01 half, 10 word, 11 dword
- req_signed  in  1  load sign-extends when 1, zero-extends when 0
- req_wdata  in  DATA_W  store data, right-justified
- rsp_valid  out  1  one-cycle response strobe
- rsp_rdata  out  DATA_W  load result; 0 for stores and for errors
- rsp_err  out  1  request was misaligned or illegal

Behaviour:
- Clock and reset: one clock, clk; reset rst is asynchronous and active-high.
- Reset values of outputs: req_ready=0, rsp_valid=0, rsp_rdata=0, rsp_err=0.
- Reset also empties the latency pipeline, so in-flight requests are dropped and produce no response.
- Stores already committed before reset keep their data unless CLEAR_ON_RESET=1.
- FSM states: CLEAR and RUN. On reset release:
  - CLEAR_ON_RESET=1: enter CLEAR. Write 0 to word index 0..2^ADDR_W-1, one word per cycle. req_ready=0 throughout. On the edge after the last word is written, go to RUN.
  - CLEAR_ON_RESET=0: go directly to RUN on the first edge after release.
- In RUN, req_ready=1 every cycle. A request is accepted on an edge where req_valid && req_ready. At most one request is accepted per cycle.
- Decode: word index = req_addr[ADDR_W+OFF_W-1:OFF_W]; offset o = req_addr[OFF_W-1:0].
- Byte lanes: byte o occupies bits [8o+7:8o].
- Error conditions:
  - half access with o[0]≠0;
  - word access with o[1:0]≠0;
  - dword access when DATA_W=32;
  - dword access with o≠0.
- On error: memory is unchanged; the response carries rsp_err=1 and rsp_rdata=0 with normal latency.
- Store: commits on the accept edge. Only the addressed lanes are written, taken from the low bytes of req_wdata; all other lanes keep their values.
- Load: the array is read at the accept edge. The selected lanes are shifted to bit 0, then extended to DATA_W by sign (req_signed=1) or zero. A word load on DATA_W=64 is extended the same way.
- Ordering: a load accepted on the edge after a store to the same word returns the new data. There is no same-edge conflict because there is a single request port.
- Latency: the accept edge is edge 0. rsp_valid is high for exactly one cycle, starting just after edge RD_LAT-1, so RD_LAT=1 behaves as a registered read.
- Responses:
  - Every accepted request, including stores and errors, yields exactly one response, in acceptance order.
  - A store response has rsp_rdata=0.
  - Back-to-back requests give back-to-back responses with no bubbles.
  - Outside a response cycle, rsp_rdata=0 and rsp_err=0.
- rst asserted during CLEAR aborts the clear. The clear restarts from index 0 after release.

Test Plan:
- Reset/clear: DATA_W=32, ADDR_W=4, CLEAR_ON_RESET=1. Release rst -> req_ready=0 for 16 cycles, then 1. A word load at address 0x3C -> rsp_rdata=0, rsp_err=0.
- Byte-lane store/load: word store 0x11223344 to 0x08, then byte store 0xAA to 0x09, then word load 0x08 -> 0x1122AA44. Signed byte load 0x09 -> 0xFFFFFFAA; unsigned byte load 0x09 -> 0x000000AA.
- Misalignment: half load at 0x05, word store at 0x0A, dword access on DATA_W=32 -> each gives rsp_err=1 and rsp_rdata=0. A following word load shows memory unchanged.
- Latency/throughput: RD_LAT=3. Issue 6 back-to-back loads -> six consecutive rsp_valid cycles, the first starting just after edge 2 following the first accept edge, data in order.
- DATA_W=64: dword store 0x0123456789ABCDEF to 0x10. Then a signed word load at 0x14 -> 0x0000000001234567; a signed half load at 0x12 -> 0xFFFFFFFFFFFF89AB.
- Reset mid-operation: RD_LAT=4, two loads in flight, assert rst -> rsp_valid=0 immediately and no responses for the dropped loads. Data stored before reset persists when CLEAR_ON_RESET=0.
